// File: rtl/uart_rx.sv
// 8N1 serial receiver with mid-bit sampling, a show-ahead receive FIFO and
// sticky framing/overrun flags that the CPU clears explicitly.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       sys_clk_i,
    input  logic       sys_rstn_i,
    input  logic       uart_rx_i,
    input  logic       uart_rd_i,
    input  logic       uart_clr_i,
    output logic [7:0] uart_dat_o,
    output logic       uart_valid_o,
    output logic       uart_full_o,
    output logic       uart_ferr_o,
    output logic       uart_ovf_o
);

    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int AW   = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);

    // state | meaning
    // IDLE  | line idle, waiting for a low level on rx_s
    // START | timing to the middle of the start bit to confirm it
    // DATA  | sampling eight data bits, LSB first
    // STOP  | sampling the stop bit and committing or dropping the byte
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_sync1;
    logic            r_sync2;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic            r_ferr;
    logic            r_ovf;

    logic            w_sample;
    logic            w_push;
    logic            w_pop;
    logic            w_can_accept;
    logic            w_ferr_set;
    logic            w_ovf_set;

    assign w_pop        = uart_rd_i && (r_count != '0);
    assign w_can_accept = (r_count < CNT_FULL) || w_pop;

    always_ff @(posedge sys_clk_i) begin
        if (!sys_rstn_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_sample   = 1'b0;
        w_push     = 1'b0;
        w_ferr_set = 1'b0;
        w_ovf_set  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_sync2) w_next = S_START;
            end
            S_START: begin
                if (r_cnt == CNT_HALF) w_next = r_sync2 ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (r_cnt == CNT_BIT) begin
                    w_sample = 1'b1;
                    if (r_bit == 3'd7) w_next = S_STOP;
                end
            end
            S_STOP: begin
                // Return to IDLE without waiting for a high line so a break re-enters START.
                if (r_cnt == CNT_BIT) begin
                    w_next = S_IDLE;
                    if (!r_sync2)         w_ferr_set = 1'b1;
                    else if (w_can_accept) w_push     = 1'b1;
                    else                   w_ovf_set  = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (!sys_rstn_i) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_sync1 <= uart_rx_i;
            r_sync2 <= r_sync1;
            if ((w_next != r_state) || (r_state == S_IDLE) || w_sample) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (r_state == S_START) begin
                r_bit <= '0;
            end else if (w_sample) begin
                r_bit <= r_bit + 3'd1;
            end
            if (w_sample) r_shift <= {r_sync2, r_shift[7:1]};
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (!sys_rstn_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ferr   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= r_shift;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_ferr_set)      r_ferr <= 1'b1;
            else if (uart_clr_i) r_ferr <= 1'b0;
            if (w_ovf_set)       r_ovf  <= 1'b1;
            else if (uart_clr_i) r_ovf  <= 1'b0;
        end
    end

    assign uart_dat_o   = r_mem[r_rd_ptr];
    assign uart_valid_o = (r_count != '0);
    assign uart_full_o  = (r_count == CNT_FULL);
    assign uart_ferr_o  = r_ferr;
    assign uart_ovf_o   = r_ovf;

endmodule
